axis_head_insert: RTL and testbench
===================================

AXIS_HEAD_INSERT -- requirements
Module: axis_head_insert

Interface
REQ-001 Parameter DSIZE, default 8: data width of every beat, 1..512.
REQ-002 Parameter LEN, default 4: header beats prepended per packet, 1..16; LEN=0 SHALL be rejected by an elaboration-time error.
REQ-003 aclk  input  1  sole clock; all state updates on rising edge.
REQ-004 aresetn  input  1  reset, asynchronous, active-low.
REQ-005 enable  input  1  per-packet insert enable; 1 = insert header, 0 = pass packet unmodified.
REQ-006 head_data  input  DSIZE*LEN  header content; beat k = bits [DSIZE*(LEN-k)-1 -: DSIZE] (beat 0 = MSB slice).
REQ-007 s_axis_tdata  input  DSIZE  upstream payload data.
REQ-008 s_axis_tvalid  input  1  upstream valid.
REQ-009 s_axis_tlast  input  1  upstream last beat of packet.
REQ-010 s_axis_tready  output  1  upstream ready.
REQ-011 m_axis_tdata  output  DSIZE  downstream data.
REQ-012 m_axis_tvalid  output  1  downstream valid.
REQ-013 m_axis_tlast  output  1  downstream last.
REQ-014 m_axis_tready  input  1  downstream ready.
REQ-015 pkt_cnt  output  16  count of packets fully emitted, i.e. handshakes with m_axis_tlast=1; wraps 0xFFFF->0.

Function
REQ-016 Two states SHALL exist: HEAD (emit header) and BODY (pass payload); a beat counter hcnt of width clog2(LEN+1) SHALL index header beats.
REQ-017 Handshake: a beat transfers on a cycle where valid and ready are both 1; m_axis_tdata/tlast SHALL be stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-018 In HEAD with hcnt=0, enable SHALL be sampled when s_axis_tvalid=1; if enable=0 the state SHALL go to BODY on the next edge with no header emitted, and that packet SHALL NOT be re-checked.
REQ-019 In HEAD with enable=1: m_axis_tvalid=s_axis_tvalid, so no header is emitted before payload is pending; s_axis_tready=0; m_axis_tlast=0.
REQ-020 In HEAD: m_axis_tdata = head_data beat 0 taken directly from the input when hcnt=0; otherwise head_reg beat hcnt.
REQ-021 On the beat-0 handshake head_reg SHALL load head_data, so one packet's header is internally consistent even if head_data changes mid-header.
REQ-022 Each header handshake SHALL increment hcnt; the handshake at hcnt=LEN-1 SHALL set state BODY and clear hcnt.
REQ-023 In BODY: m_axis_tdata=s_axis_tdata, m_axis_tvalid=s_axis_tvalid, m_axis_tlast=s_axis_tlast, s_axis_tready=m_axis_tready; zero added latency, purely combinational path.
REQ-024 A BODY handshake with s_axis_tlast=1 SHALL return state to HEAD with hcnt=0 and increment pkt_cnt on that same edge.
REQ-025 A single-beat payload (tlast on first beat) SHALL yield LEN header beats followed by exactly one payload beat carrying tlast.
REQ-026 Back-to-back packets SHALL incur no idle cycle: the first header beat of packet N+1 is valid in the cycle after packet N's tlast handshake, if s_axis_tvalid=1.
REQ-027 Downstream stalls (m_axis_tready=0) at any header or payload beat SHALL hold hcnt, state and outputs unchanged.
REQ-028 Header beats never carry tlast; payload bytes SHALL NOT be dropped, duplicated or reordered.

Reset
REQ-029 aresetn=0 SHALL immediately set state=HEAD, hcnt=0, head_reg=0, pkt_cnt=0, and force m_axis_tvalid=0 and s_axis_tready=0 independent of the clock.
REQ-030 Reset asserted mid-packet SHALL abandon the packet; after release the next accepted upstream beat is treated as the start of a new packet.

Verification
REQ-031 LEN=4, DSIZE=8, head_data=0x11223344, enable=1, payload A0,A1,A2(last), m_axis_tready=1 -> output 11,22,33,44,A0,A1,A2(tlast) in 7 consecutive cycles; pkt_cnt=1.
REQ-032 Same stimulus with head_data changed to 0x55667788 after the 0x11 beat -> output still 11,22,33,44; next packet starts with 55.
REQ-033 enable=0 at packet start, payload B0,B1(last) -> output B0,B1(tlast) only; following packet with enable=1 gets its header.
REQ-034 m_axis_tready toggled 1,0,0,1,... pseudo-randomly over 100 packets of 1..20 beats -> output equals the header+payload golden model; pkt_cnt=100; stable data under stall.
REQ-035 Two back-to-back single-beat packets, s_axis_tvalid held 1 -> 2*(LEN+1) consecutive valid beats, no bubbles.
REQ-036 aresetn pulsed low during header beat 2 -> m_axis_tvalid=0 asynchronously; pkt_cnt=0; next packet after release emits its full header from beat 0.

Source files
------------

// File: rtl/axis_head_insert.sv
// AXI-Stream header inserter: prepends LEN header beats to each packet.
// Ports: aclk/aresetn, enable, head_data, s_axis_* in, m_axis_* out, pkt_cnt.
module axis_head_insert #(
  parameter int DSIZE = 8,
  parameter int LEN   = 4
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  enable,
  input  logic [DSIZE*LEN-1:0]  head_data,
  input  logic [DSIZE-1:0]      s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  output logic [DSIZE-1:0]      m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic [15:0]           pkt_cnt
);

  generate
    if (LEN < 1 || LEN > 16) begin : g_len_bad
      $error("axis_head_insert: LEN must be 1..16");
    end
    if (DSIZE < 1 || DSIZE > 512) begin : g_dsize_bad
      $error("axis_head_insert: DSIZE must be 1..512");
    end
  endgenerate

  localparam int HW = $clog2(LEN + 1);
  localparam logic [HW-1:0] LAST = HW'(LEN - 1);

  typedef enum logic {
    HEAD,
    BODY
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [HW-1:0]          hcnt;
  logic [HW-1:0]          hcnt_nxt;
  logic [DSIZE*LEN-1:0]   head_reg;
  logic [DSIZE-1:0]       head0;
  logic [DSIZE-1:0]       reg_beat;
  logic                   load;
  logic                   cnt_inc;

  // Beat 0 comes straight from the input so the first header
  // beat needs no prior capture; later beats use the snapshot.
  assign head0 = head_data[DSIZE*LEN-1 -: DSIZE];

  always_comb begin
    reg_beat = '0;
    for (int k = 0; k < LEN; k++) begin
      if (hcnt == HW'(k)) begin
        reg_beat = head_reg[DSIZE*(LEN-k)-1 -: DSIZE];
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    hcnt_nxt      = hcnt;
    m_axis_tdata  = s_axis_tdata;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    s_axis_tready = 1'b0;
    load          = 1'b0;
    cnt_inc       = 1'b0;
    unique case (state)
      HEAD: begin
        if (hcnt == '0 && !enable) begin
          // Bypass decided once per packet; BODY runs to tlast.
          if (s_axis_tvalid) begin
            state_nxt = BODY;
          end
        end else begin
          // Header only goes out once payload is pending.
          m_axis_tvalid = s_axis_tvalid;
          m_axis_tdata  = (hcnt == '0) ? head0 : reg_beat;
          if (s_axis_tvalid && m_axis_tready) begin
            load = (hcnt == '0);
            if (hcnt == LAST) begin
              state_nxt = BODY;
              hcnt_nxt  = '0;
            end else begin
              hcnt_nxt = hcnt + 1'b1;
            end
          end
        end
      end
      BODY: begin
        m_axis_tvalid = s_axis_tvalid;
        m_axis_tlast  = s_axis_tlast;
        s_axis_tready = m_axis_tready;
        if (s_axis_tvalid && m_axis_tready && s_axis_tlast) begin
          state_nxt = HEAD;
          hcnt_nxt  = '0;
          cnt_inc   = 1'b1;
        end
      end
      default: begin
        state_nxt = HEAD;
        hcnt_nxt  = '0;
      end
    endcase
    // Handshake outputs drop as soon as reset asserts.
    if (!aresetn) begin
      m_axis_tvalid = 1'b0;
      s_axis_tready = 1'b0;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state    <= HEAD;
      hcnt     <= '0;
      head_reg <= '0;
      pkt_cnt  <= '0;
    end else begin
      state <= state_nxt;
      hcnt  <= hcnt_nxt;
      if (load) begin
        head_reg <= head_data;
      end
      if (cnt_inc) begin
        pkt_cnt <= pkt_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_axis_head_insert.sv
// Testbench for axis_head_insert: scoreboard of header+payload beats.
// Drives DSIZE=8, LEN=4 through directed and random packet scenarios.
module tb_axis_head_insert;

  localparam int DSIZE = 8;
  localparam int LEN   = 4;

  logic             aclk = 1'b0;
  logic             aresetn = 1'b1;
  logic             enable = 1'b0;
  logic [31:0]      head_data = '0;
  logic [7:0]       s_tdata = '0;
  logic             s_tvalid = 1'b0;
  logic             s_tlast = 1'b0;
  logic             s_tready;
  logic [7:0]       m_tdata;
  logic             m_tvalid;
  logic             m_tlast;
  logic             m_tready = 1'b1;
  logic [15:0]      pkt_cnt;

  axis_head_insert #(.DSIZE(DSIZE), .LEN(LEN)) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .enable        (enable),
    .head_data     (head_data),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tlast  (s_tlast),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tlast  (m_tlast),
    .m_axis_tready (m_tready),
    .pkt_cnt       (pkt_cnt)
  );

  always #5 aclk = ~aclk;

  int          total = 0;
  int          bad = 0;
  logic [8:0]  exp_q[$];
  logic [8:0]  e;
  bit          mon_on = 1'b0;
  int          cyc = 0;
  int          hs_n = 0;
  int          first_hs = 0;
  int          last_hs = 0;
  bit          hold_v = 1'b0;
  logic [7:0]  hold_d;
  logic        hold_l;
  bit          rnd_on = 1'b0;

  always @(posedge aclk) cyc <= cyc + 1;

  always @(negedge aclk) begin
    if (!mon_on || !aresetn) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        total++;
        if (m_tvalid !== 1'b1 || m_tdata !== hold_d || m_tlast !== hold_l) begin
          bad++;
          $display("FAIL stall_hold: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                   m_tvalid, m_tdata, m_tlast, hold_d, hold_l);
        end
      end
      if (m_tvalid === 1'b1 && m_tready === 1'b1) begin
        if (hs_n == 0) first_hs = cyc;
        last_hs = cyc;
        hs_n++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL extra_beat: got d=%h l=%b want no beat", m_tdata, m_tlast);
        end else begin
          e = exp_q.pop_front();
          if ({m_tlast, m_tdata} !== e) begin
            bad++;
            $display("FAIL beat: got l=%b d=%h want l=%b d=%h",
                     m_tlast, m_tdata, e[8], e[7:0]);
          end
        end
      end
      hold_v = (m_tvalid === 1'b1) && (m_tready !== 1'b1);
      hold_d = m_tdata;
      hold_l = m_tlast;
    end
  end

  task automatic clr_stats();
    hs_n = 0;
    first_hs = 0;
    last_hs = 0;
  endtask

  task automatic send_pkt(input bit en, input int n, input logic [7:0] base);
    logic [31:0] h;
    bit          hs;
    int          t;
    h = head_data;
    if (en) begin
      for (int k = 0; k < LEN; k++) exp_q.push_back({1'b0, h[31-8*k -: 8]});
    end
    for (int i = 0; i < n; i++) exp_q.push_back({(i == n - 1), 8'(base + i)});
    enable = en;
    for (int i = 0; i < n; i++) begin
      s_tdata  = 8'(base + i);
      s_tlast  = (i == n - 1);
      s_tvalid = 1'b1;
      t = 0;
      forever begin
        @(negedge aclk);
        hs = (s_tready === 1'b1);
        @(posedge aclk);
        #1;
        if (hs) break;
        t++;
        if (t > 1000) begin
          total++;
          bad++;
          $display("FAIL upstream_timeout: got no s_tready in %0d cycles want accept", t);
          break;
        end
      end
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic drain(input int lim);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < lim) begin
      @(posedge aclk);
      #1;
      t++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d beats pending want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    s_tvalid = 1'b1;
    enable   = 1'b1;
    #2 aresetn = 1'b0;
    #1;
    total++;
    if (m_tvalid !== 1'b0 || s_tready !== 1'b0 || pkt_cnt !== 16'd0) begin
      bad++;
      $display("FAIL reset_state: got v=%b r=%b cnt=%0d want 0 0 0",
               m_tvalid, s_tready, pkt_cnt);
    end
    s_tvalid = 1'b0;
    @(posedge aclk);
    #1 aresetn = 1'b1;
    @(posedge aclk);
    #1 mon_on = 1'b1;
  endtask

  task automatic test_basic();
    logic [15:0] c0;
    head_data = 32'h11223344;
    m_tready  = 1'b1;
    clr_stats();
    c0 = pkt_cnt;
    send_pkt(1'b1, 3, 8'hA0);
    drain(100);
    total++;
    if (hs_n != 7 || last_hs - first_hs + 1 != 7) begin
      bad++;
      $display("FAIL basic_span: got beats=%0d span=%0d want 7 7",
               hs_n, last_hs - first_hs + 1);
    end
    total++;
    if (16'(pkt_cnt - c0) !== 16'd1) begin
      bad++;
      $display("FAIL basic_cnt: got delta=%0d want 1", 16'(pkt_cnt - c0));
    end
  endtask

  task automatic test_head_change();
    logic [15:0] c0;
    head_data = 32'h11223344;
    c0 = pkt_cnt;
    fork
      send_pkt(1'b1, 3, 8'hA0);
      begin
        for (int t = 0; t < 50; t++) begin
          @(negedge aclk);
          if (m_tvalid === 1'b1 && m_tready === 1'b1) break;
        end
        @(posedge aclk);
        #2 head_data = 32'h55667788;
      end
    join
    send_pkt(1'b1, 2, 8'hC0);
    drain(100);
    total++;
    if (16'(pkt_cnt - c0) !== 16'd2) begin
      bad++;
      $display("FAIL head_change_cnt: got delta=%0d want 2", 16'(pkt_cnt - c0));
    end
  endtask

  task automatic test_bypass();
    logic [15:0] c0;
    head_data = 32'h99AABBCC;
    clr_stats();
    c0 = pkt_cnt;
    send_pkt(1'b0, 2, 8'hB0);
    send_pkt(1'b1, 2, 8'hD0);
    drain(100);
    total++;
    if (hs_n != 8 || 16'(pkt_cnt - c0) !== 16'd2) begin
      bad++;
      $display("FAIL bypass: got beats=%0d delta=%0d want 8 2",
               hs_n, 16'(pkt_cnt - c0));
    end
  endtask

  task automatic test_back_to_back();
    head_data = 32'hDEADBEEF;
    m_tready  = 1'b1;
    clr_stats();
    send_pkt(1'b1, 1, 8'hE0);
    send_pkt(1'b1, 1, 8'hE1);
    drain(100);
    total++;
    if (hs_n != 10 || last_hs - first_hs + 1 != 10) begin
      bad++;
      $display("FAIL back_to_back: got beats=%0d span=%0d want 10 10",
               hs_n, last_hs - first_hs + 1);
    end
  endtask

  task automatic test_random();
    logic [15:0] c0;
    int          g;
    head_data = 32'h0F1E2D3C;
    c0 = pkt_cnt;
    rnd_on = 1'b1;
    fork
      while (rnd_on) begin
        @(posedge aclk);
        #1 m_tready = 1'($urandom_range(0, 1));
      end
    join_none
    for (int p = 0; p < 100; p++) begin
      send_pkt($urandom_range(0, 3) != 0, $urandom_range(1, 20), 8'($urandom));
      g = $urandom_range(0, 2);
      repeat (g) begin
        @(posedge aclk);
        #1;
      end
    end
    drain(2000);
    rnd_on = 1'b0;
    @(posedge aclk);
    #2 m_tready = 1'b1;
    total++;
    if (16'(pkt_cnt - c0) !== 16'd100) begin
      bad++;
      $display("FAIL random_cnt: got delta=%0d want 100", 16'(pkt_cnt - c0));
    end
  endtask

  task automatic test_reset_mid();
    head_data = 32'h11223344;
    m_tready  = 1'b1;
    mon_on    = 1'b0;
    enable    = 1'b1;
    s_tdata   = 8'hC0;
    s_tlast   = 1'b1;
    s_tvalid  = 1'b1;
    @(posedge aclk);
    #1;
    @(posedge aclk);
    #1;
    total++;
    if (m_tvalid !== 1'b1 || m_tdata !== 8'h33) begin
      bad++;
      $display("FAIL mid_hdr2: got v=%b d=%h want v=1 d=33", m_tvalid, m_tdata);
    end
    #2 aresetn = 1'b0;
    #1;
    total++;
    if (m_tvalid !== 1'b0 || s_tready !== 1'b0 || pkt_cnt !== 16'd0) begin
      bad++;
      $display("FAIL mid_reset: got v=%b r=%b cnt=%0d want 0 0 0",
               m_tvalid, s_tready, pkt_cnt);
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    exp_q.delete();
    @(posedge aclk);
    #1 aresetn = 1'b1;
    @(posedge aclk);
    #1 mon_on = 1'b1;
    clr_stats();
    send_pkt(1'b1, 1, 8'hC0);
    drain(100);
    total++;
    if (hs_n != 5 || last_hs - first_hs + 1 != 5 || pkt_cnt !== 16'd1) begin
      bad++;
      $display("FAIL after_reset: got beats=%0d span=%0d cnt=%0d want 5 5 1",
               hs_n, last_hs - first_hs + 1, pkt_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_head_change();
    test_bypass();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
